image_readout_controller: RTL and testbench

//  Downstream of the UART RX controller: on a cntrlReadData pulse it scans the rectangular pixel window

---
 rtl/image_readout_controller_pkg.sv | 36 +++
 rtl/image_readout_controller_if.sv | 32 +++
 rtl/readout_addr_gen.sv | 91 +++++++++
 rtl/image_readout_controller.sv | 167 ++++++++++++++++
 tb/tb_image_readout_controller.sv | 215 +++++++++++++++++++++
 5 files changed

// File: rtl/image_readout_controller_pkg.sv
// Shared types and constants for the image readout controller.
// Frame bytes and state encoding are also documented for host software.
package image_readout_controller_pkg;

  localparam int DEF_IMG_W   = 256;
  localparam int DEF_IMG_H   = 256;
  localparam int DEF_ADDR_W  = 16;
  localparam int DEF_MEM_LAT = 2;

  localparam logic [7:0] HDR0_BYTE = 8'h24;
  localparam logic [7:0] HDR1_BYTE = 8'h44;
  localparam logic [7:0] TRL0_BYTE = 8'h24;
  localparam logic [7:0] TRL1_BYTE = 8'h45;

  typedef enum logic [3:0] {
    S_IDLE,
    S_HDR0,
    S_HDR1,
    S_RD,
    S_WAIT,
    S_SENDLO,
    S_SENDHI,
    S_NEXT,
    S_TRL0,
    S_TRL1,
    S_DONE
  } state_t;

  function automatic logic [15:0] clamp16(
    input logic [15:0] v,
    input logic [15:0] lim
  );
    return (v > lim) ? lim : v;
  endfunction

endpackage

// File: rtl/image_readout_controller_if.sv
// Image memory read port and UART TX FIFO write port.
// master = readout controller, slave = memory / FIFO side.
interface image_readout_controller_if #(
  parameter int ADDR_W = 16
);

  logic [ADDR_W-1:0] memAddr;
  logic              memRdEn;
  logic [15:0]       memRdData;
  logic [7:0]        txDataIn;
  logic              txBufferWrite;
  logic              txBufferFull;

  modport master (
    output memAddr,
    output memRdEn,
    input  memRdData,
    output txDataIn,
    output txBufferWrite,
    input  txBufferFull
  );

  modport slave (
    input  memAddr,
    input  memRdEn,
    output memRdData,
    input  txDataIn,
    input  txBufferWrite,
    output txBufferFull
  );

endinterface

// File: rtl/readout_addr_gen.sv
// Window scan counters: x/y position, incremental row base, clamping.
// load latches a new window, step advances one pixel in row-major order.
module readout_addr_gen
  import image_readout_controller_pkg::*;
#(
  parameter int IMG_W  = DEF_IMG_W,
  parameter int IMG_H  = DEF_IMG_H,
  parameter int ADDR_W = DEF_ADDR_W
) (
  input  logic              clk,
  input  logic              resetN,
  input  logic              load_i,
  input  logic              step_i,
  input  logic [15:0]       start_x_i,
  input  logic [15:0]       start_y_i,
  input  logic [15:0]       end_x_i,
  input  logic [15:0]       end_y_i,
  output logic [ADDR_W-1:0] addr_o,
  output logic              empty_o,
  output logic              last_o
);

  // Row base is loaded by shift, so IMG_W is a power of two.
  localparam int          XSH   = $clog2(IMG_W);
  localparam logic [15:0] MAX_X = 16'(IMG_W - 1);
  localparam logic [15:0] MAX_Y = 16'(IMG_H - 1);

  logic [15:0]       sx_q, sx_d;
  logic [15:0]       ex_q, ex_d;
  logic [15:0]       ey_q, ey_d;
  logic [15:0]       x_q, x_d;
  logic [15:0]       y_q, y_d;
  logic [ADDR_W-1:0] row_q, row_d;
  logic              empty_q, empty_d;
  logic [15:0]       ex_c, ey_c;

  assign ex_c = clamp16(end_x_i, MAX_X);
  assign ey_c = clamp16(end_y_i, MAX_Y);

  always_comb begin
    sx_d    = sx_q;
    ex_d    = ex_q;
    ey_d    = ey_q;
    x_d     = x_q;
    y_d     = y_q;
    row_d   = row_q;
    empty_d = empty_q;
    if (load_i) begin
      sx_d    = start_x_i;
      ex_d    = ex_c;
      ey_d    = ey_c;
      x_d     = start_x_i;
      y_d     = start_y_i;
      row_d   = ADDR_W'(start_y_i) << XSH;
      empty_d = (start_x_i > ex_c) || (start_y_i > ey_c);
    end else if (step_i) begin
      if (x_q < ex_q) begin
        x_d = x_q + 16'd1;
      end else begin
        x_d   = sx_q;
        y_d   = y_q + 16'd1;
        row_d = row_q + ADDR_W'(IMG_W);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!resetN) begin
      sx_q    <= '0;
      ex_q    <= '0;
      ey_q    <= '0;
      x_q     <= '0;
      y_q     <= '0;
      row_q   <= '0;
      empty_q <= 1'b0;
    end else begin
      sx_q    <= sx_d;
      ex_q    <= ex_d;
      ey_q    <= ey_d;
      x_q     <= x_d;
      y_q     <= y_d;
      row_q   <= row_d;
      empty_q <= empty_d;
    end
  end

  assign addr_o  = row_q + ADDR_W'(x_q);
  assign empty_o = empty_q;
  assign last_o  = (x_q >= ex_q) && (y_q >= ey_q);

endmodule

// File: rtl/image_readout_controller.sv
// Scans a pixel window of the image memory, shifts each count,
// and streams a '$D' .. '$E' framed byte stream into the TX FIFO.
module image_readout_controller
  import image_readout_controller_pkg::*;
#(
  parameter int IMG_W       = DEF_IMG_W,
  parameter int IMG_H       = DEF_IMG_H,
  parameter int ADDR_W      = DEF_ADDR_W,
  parameter int MEM_LATENCY = DEF_MEM_LAT
) (
  input  logic                        clk,
  input  logic                        resetN,
  input  logic                        cntrlReadData,
  input  logic [15:0]                 readStartX,
  input  logic [15:0]                 readStartY,
  input  logic [15:0]                 readEndX,
  input  logic [15:0]                 readEndY,
  input  logic [7:0]                  readDivide,
  image_readout_controller_if.master  bus,
  output logic                        readBusy,
  output logic                        readDone
);

  localparam logic [7:0] LAT_LAST = 8'(MEM_LATENCY - 1);

  state_t      state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [7:0]  div_q, div_d;
  logic [15:0] pix_q, pix_d;

  logic              load, step;
  logic              empty, last;
  logic [ADDR_W-1:0] addr;
  logic              rd_en, wr_en, done;
  logic [7:0]        tx_byte;

  readout_addr_gen #(
    .IMG_W  (IMG_W),
    .IMG_H  (IMG_H),
    .ADDR_W (ADDR_W)
  ) u_addr (
    .clk       (clk),
    .resetN    (resetN),
    .load_i    (load),
    .step_i    (step),
    .start_x_i (readStartX),
    .start_y_i (readStartY),
    .end_x_i   (readEndX),
    .end_y_i   (readEndY),
    .addr_o    (addr),
    .empty_o   (empty),
    .last_o    (last)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    div_d   = div_q;
    pix_d   = pix_q;
    load    = 1'b0;
    step    = 1'b0;
    rd_en   = 1'b0;
    wr_en   = 1'b0;
    done    = 1'b0;
    tx_byte = 8'h00;
    unique case (state_q)
      S_IDLE: begin
        if (cntrlReadData) begin
          load    = 1'b1;
          div_d   = readDivide;
          state_d = S_HDR0;
        end
      end
      S_HDR0: begin
        if (!bus.txBufferFull) begin
          wr_en   = 1'b1;
          tx_byte = HDR0_BYTE;
          state_d = S_HDR1;
        end
      end
      S_HDR1: begin
        if (!bus.txBufferFull) begin
          wr_en   = 1'b1;
          tx_byte = HDR1_BYTE;
          state_d = empty ? S_TRL0 : S_RD;
        end
      end
      S_RD: begin
        rd_en   = 1'b1;
        cnt_d   = 8'd0;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        if (cnt_q == LAT_LAST) begin
          pix_d   = (div_q >= 8'd16) ? 16'h0000
                                     : (bus.memRdData >> div_q);
          state_d = S_SENDLO;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      S_SENDLO: begin
        if (!bus.txBufferFull) begin
          wr_en   = 1'b1;
          tx_byte = pix_q[7:0];
          state_d = S_SENDHI;
        end
      end
      S_SENDHI: begin
        if (!bus.txBufferFull) begin
          wr_en   = 1'b1;
          tx_byte = pix_q[15:8];
          state_d = S_NEXT;
        end
      end
      S_NEXT: begin
        if (last) begin
          state_d = S_TRL0;
        end else begin
          step    = 1'b1;
          state_d = S_RD;
        end
      end
      S_TRL0: begin
        if (!bus.txBufferFull) begin
          wr_en   = 1'b1;
          tx_byte = TRL0_BYTE;
          state_d = S_TRL1;
        end
      end
      S_TRL1: begin
        if (!bus.txBufferFull) begin
          wr_en   = 1'b1;
          tx_byte = TRL1_BYTE;
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        done    = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!resetN) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      div_q   <= '0;
      pix_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      div_q   <= div_d;
      pix_q   <= pix_d;
    end
  end

  assign bus.memRdEn       = rd_en;
  assign bus.memAddr       = rd_en ? addr : '0;
  assign bus.txBufferWrite = wr_en;
  assign bus.txDataIn      = tx_byte;
  assign readBusy          = (state_q != S_IDLE);
  assign readDone          = done;

endmodule

// File: tb/tb_image_readout_controller.sv
// Directed bench for image_readout_controller: frame bytes,
// addresses, back-pressure, clamping, mid-scan reset, start while busy.
module tb_image_readout_controller;

  logic        clk = 1'b0;
  logic        resetN = 1'b0;
  logic        cntrlReadData = 1'b0;
  logic [15:0] readStartX = '0;
  logic [15:0] readStartY = '0;
  logic [15:0] readEndX = '0;
  logic [15:0] readEndY = '0;
  logic [7:0]  readDivide = '0;
  logic        readBusy;
  logic        readDone;

  image_readout_controller_if #(.ADDR_W(16)) bus ();

  image_readout_controller dut (
    .clk           (clk),
    .resetN        (resetN),
    .cntrlReadData (cntrlReadData),
    .readStartX    (readStartX),
    .readStartY    (readStartY),
    .readEndX      (readEndX),
    .readEndY      (readEndY),
    .readDivide    (readDivide),
    .bus           (bus),
    .readBusy      (readBusy),
    .readDone      (readDone)
  );

  always #5 clk = ~clk;

  logic [15:0] mem [0:65535];
  logic [15:0] st1 = '0;
  logic [15:0] st2 = '0;
  int          cyc = 0;
  logic        bp_en = 1'b0;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (bus.memRdEn) st1 <= mem[bus.memAddr];
    st2 <= st1;
  end

  assign bus.memRdData    = st2;
  assign bus.txBufferFull = bp_en && ((cyc % 6) != 5);

  logic [7:0]  bytes_q [$];
  logic [15:0] addr_q [$];
  int          done_cnt = 0;
  int          viol = 0;

  always @(posedge clk) begin
    if (bus.txBufferWrite) bytes_q.push_back(bus.txDataIn);
    if (bus.txBufferWrite && bus.txBufferFull) viol++;
    if (bus.memRdEn) addr_q.push_back(bus.memAddr);
    if (readDone) done_cnt++;
  end

  int n_chk = 0;
  int n_pass = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  typedef struct {
    logic [15:0] x0, y0, x1, y1;
    logic [7:0]  dv;
    logic        bp;
    int          nb;
    logic [7:0]  b [12];
    int          nr;
    logic [15:0] a [4];
  } vec_t;

  vec_t vec [9];

  task automatic clear_mon();
    bytes_q.delete();
    addr_q.delete();
    done_cnt = 0;
  endtask

  task automatic start_frame(input vec_t v);
    readStartX = v.x0;
    readStartY = v.y0;
    readEndX   = v.x1;
    readEndY   = v.y1;
    readDivide = v.dv;
    bp_en      = v.bp;
    @(negedge clk);
    cntrlReadData = 1'b1;
    @(negedge clk);
    cntrlReadData = 1'b0;
  endtask

  task automatic wait_done(input string name);
    for (int i = 0; i < 3000 && done_cnt == 0; i++) @(negedge clk);
    if (done_cnt == 0) chk({name, "_timeout"}, 0, 1);
    repeat (10) @(negedge clk);
  endtask

  initial begin
    for (int i = 0; i < 65536; i++) mem[i] = 16'(i * 7 + 3);
    mem[0]     = 16'h1234;
    mem[1]     = 16'h00FF;
    mem[258]   = 16'hA1B2;
    mem[259]   = 16'h0C0D;
    mem[514]   = 16'h1000;
    mem[515]   = 16'hFFFF;
    mem[1022]  = 16'h5566;
    mem[1023]  = 16'h7788;
    mem[65280] = 16'hBEEF;

    vec[0] = '{x0:0, y0:0, x1:1, y1:0, dv:0, bp:0, nb:8,
      b:'{8'h24,8'h44,8'h34,8'h12,8'hFF,8'h00,8'h24,8'h45,0,0,0,0},
      nr:2, a:'{0,1,0,0}};
    vec[1] = '{x0:0, y0:0, x1:1, y1:0, dv:4, bp:0, nb:8,
      b:'{8'h24,8'h44,8'h23,8'h01,8'h0F,8'h00,8'h24,8'h45,0,0,0,0},
      nr:2, a:'{0,1,0,0}};
    vec[2] = '{x0:0, y0:0, x1:1, y1:0, dv:20, bp:0, nb:8,
      b:'{8'h24,8'h44,8'h00,8'h00,8'h00,8'h00,8'h24,8'h45,0,0,0,0},
      nr:2, a:'{0,1,0,0}};
    vec[3] = '{x0:2, y0:1, x1:3, y1:2, dv:0, bp:0, nb:12,
      b:'{8'h24,8'h44,8'hB2,8'hA1,8'h0D,8'h0C,8'h00,8'h10,8'hFF,8'hFF,8'h24,8'h45},
      nr:4, a:'{258,259,514,515}};
    vec[4] = '{x0:0, y0:0, x1:1, y1:0, dv:0, bp:1, nb:8,
      b:'{8'h24,8'h44,8'h34,8'h12,8'hFF,8'h00,8'h24,8'h45,0,0,0,0},
      nr:2, a:'{0,1,0,0}};
    vec[5] = '{x0:5, y0:0, x1:3, y1:0, dv:0, bp:0, nb:4,
      b:'{8'h24,8'h44,8'h24,8'h45,0,0,0,0,0,0,0,0},
      nr:0, a:'{0,0,0,0}};
    vec[6] = '{x0:254, y0:3, x1:1000, y1:3, dv:0, bp:0, nb:8,
      b:'{8'h24,8'h44,8'h66,8'h55,8'h88,8'h77,8'h24,8'h45,0,0,0,0},
      nr:2, a:'{1022,1023,0,0}};
    vec[7] = '{x0:0, y0:255, x1:0, y1:1000, dv:0, bp:0, nb:6,
      b:'{8'h24,8'h44,8'hEF,8'hBE,8'h24,8'h45,0,0,0,0,0,0},
      nr:1, a:'{65280,0,0,0}};
    vec[8] = '{x0:0, y0:2, x1:0, y1:1, dv:0, bp:0, nb:4,
      b:'{8'h24,8'h44,8'h24,8'h45,0,0,0,0,0,0,0,0},
      nr:0, a:'{0,0,0,0}};

    repeat (3) @(negedge clk);
    chk("rst_memAddr", int'(bus.memAddr), 0);
    chk("rst_memRdEn", int'(bus.memRdEn), 0);
    chk("rst_txDataIn", int'(bus.txDataIn), 0);
    chk("rst_txWrite", int'(bus.txBufferWrite), 0);
    chk("rst_busy", int'(readBusy), 0);
    chk("rst_done", int'(readDone), 0);
    resetN = 1'b1;
    repeat (2) @(negedge clk);

    for (int i = 0; i < 9; i++) begin
      string tag;
      tag = $sformatf("v%0d", i);
      clear_mon();
      start_frame(vec[i]);
      chk({tag, "_busy"}, int'(readBusy), 1);
      wait_done(tag);
      bp_en = 1'b0;
      chk({tag, "_nbytes"}, bytes_q.size(), vec[i].nb);
      for (int k = 0; k < vec[i].nb && k < bytes_q.size(); k++)
        chk($sformatf("%s_byte%0d", tag, k), int'(bytes_q[k]), int'(vec[i].b[k]));
      chk({tag, "_nreads"}, addr_q.size(), vec[i].nr);
      for (int k = 0; k < vec[i].nr && k < addr_q.size(); k++)
        chk($sformatf("%s_addr%0d", tag, k), int'(addr_q[k]), int'(vec[i].a[k]));
      chk({tag, "_done"}, done_cnt, 1);
      chk({tag, "_idle"}, int'(readBusy), 0);
    end
    chk("bp_write_while_full", viol, 0);

    // Reset in the middle of a frame.
    clear_mon();
    start_frame(vec[0]);
    for (int i = 0; i < 200 && bytes_q.size() < 3; i++) @(negedge clk);
    chk("mid_reached3", int'(bytes_q.size() >= 3), 1);
    resetN = 1'b0;
    @(negedge clk);
    chk("mid_busy", int'(readBusy), 0);
    chk("mid_memRdEn", int'(bus.memRdEn), 0);
    chk("mid_memAddr", int'(bus.memAddr), 0);
    chk("mid_txWrite", int'(bus.txBufferWrite), 0);
    chk("mid_txDataIn", int'(bus.txDataIn), 0);
    chk("mid_done", int'(readDone), 0);
    resetN = 1'b1;
    begin
      int snap;
      snap = bytes_q.size();
      repeat (30) @(negedge clk);
      chk("mid_no_more_bytes", bytes_q.size(), snap);
      chk("mid_no_done", done_cnt, 0);
    end

    // Second start pulse while busy must be ignored.
    clear_mon();
    start_frame(vec[0]);
    repeat (3) @(negedge clk);
    cntrlReadData = 1'b1;
    @(negedge clk);
    cntrlReadData = 1'b0;
    wait_done("busy");
    repeat (40) @(negedge clk);
    chk("busy_nbytes", bytes_q.size(), 8);
    chk("busy_done", done_cnt, 1);
    chk("busy_nreads", addr_q.size(), 2);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
